// File: rtl/alu_pkg.sv
// Shared ALU opcode map, legality helpers and driver FSM encoding.
package alu_pkg;

  localparam int unsigned ALU_OP_AND     = 32'h0;
  localparam int unsigned ALU_OP_OR      = 32'h1;
  localparam int unsigned ALU_OP_NOR     = 32'h2;
  localparam int unsigned ALU_OP_XOR     = 32'h3;
  localparam int unsigned ALU_OP_ADD     = 32'h4;
  localparam int unsigned ALU_OP_SUB     = 32'h5;
  localparam int unsigned ALU_OP_MULT    = 32'h6;
  localparam int unsigned ALU_OP_SLT     = 32'h7;
  localparam int unsigned ALU_OP_SRL     = 32'h8;
  localparam int unsigned ALU_OP_SLL     = 32'h9;
  localparam int unsigned ALU_OP_SRA     = 32'hA;
  localparam int unsigned ALU_OP_SHIFT_B = 32'hB;
  localparam int unsigned ALU_OP_LTZ     = 32'hC;
  localparam int unsigned ALU_OP_LEZ     = 32'hD;
  localparam int unsigned ALU_OP_GEZ     = 32'hE;
  localparam int unsigned ALU_OP_MAX     = 32'hE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Opcodes above ALU_OP_MAX are rejected without touching the ALU.
  function automatic logic op_is_legal(input logic [31:0] op);
    return op <= ALU_OP_MAX;
  endfunction

  // Only the shift group consumes a shift amount.
  function automatic logic op_uses_shamt(input logic [31:0] op);
    return (op >= ALU_OP_SRL) && (op <= ALU_OP_SHIFT_B);
  endfunction

endpackage

// File: rtl/alu_driver.sv
// Sequential initiator: one request at a time, drives the ALU for a fixed
// latency, captures the result and holds it on a valid/ready response channel.
module alu_driver
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CTRL_WIDTH   = 5,
  parameter int unsigned STATUS_WIDTH = 4,
  parameter int unsigned SHAMT_WIDTH  = 5,
  parameter int unsigned LATENCY      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [DATA_WIDTH-1:0]     req_a,
  input  logic [DATA_WIDTH-1:0]     req_b,
  input  logic [CTRL_WIDTH-1:0]     req_op,
  input  logic [SHAMT_WIDTH-1:0]    req_shamt,
  output logic                      alu_en_n,
  output logic [2*DATA_WIDTH-1:0]   alu_dataIn,
  output logic [CTRL_WIDTH-1:0]     alu_ctrl,
  output logic [SHAMT_WIDTH-1:0]    alu_shamt,
  input  logic [DATA_WIDTH-1:0]     alu_dataOut,
  input  logic [STATUS_WIDTH-1:0]   alu_status,
  input  logic [DATA_WIDTH-1:0]     alu_hi,
  input  logic [DATA_WIDTH-1:0]     alu_lo,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic [STATUS_WIDTH-1:0]   rsp_status,
  output logic [DATA_WIDTH-1:0]     rsp_hi,
  output logic [DATA_WIDTH-1:0]     rsp_lo,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      req_ready_q, req_ready_d;
  logic                      alu_en_n_q, alu_en_n_d;
  logic [2*DATA_WIDTH-1:0]   alu_data_in_q, alu_data_in_d;
  logic [CTRL_WIDTH-1:0]     alu_ctrl_q, alu_ctrl_d;
  logic [SHAMT_WIDTH-1:0]    alu_shamt_q, alu_shamt_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic [STATUS_WIDTH-1:0]   rsp_status_q, rsp_status_d;
  logic [DATA_WIDTH-1:0]     rsp_hi_q, rsp_hi_d;
  logic [DATA_WIDTH-1:0]     rsp_lo_q, rsp_lo_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      busy_q, busy_d;

  // Next-state and next-output logic; ALU-side outputs are nonzero only in ISSUE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready_q;
    alu_en_n_d    = alu_en_n_q;
    alu_data_in_d = alu_data_in_q;
    alu_ctrl_d    = alu_ctrl_q;
    alu_shamt_d   = alu_shamt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    rsp_hi_d      = rsp_hi_q;
    rsp_lo_d      = rsp_lo_q;
    rsp_err_d     = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_ready_q && req_valid) begin
          req_ready_d = 1'b0;
          if (op_is_legal(32'(req_op))) begin
            state_d       = ST_ISSUE;
            cnt_d         = CNT_LOAD;
            alu_en_n_d    = 1'b0;
            alu_data_in_d = {req_a, req_b};
            alu_ctrl_d    = req_op;
            alu_shamt_d   = op_uses_shamt(32'(req_op)) ? req_shamt : '0;
          end else begin
            state_d      = ST_RESP;
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_data_d   = '0;
            rsp_status_d = '0;
          end
        end
      end

      ST_ISSUE: begin
        if (cnt_q == '0) begin
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = alu_dataOut;
          rsp_status_d = alu_status;
          rsp_err_d    = 1'b0;
          if (32'(alu_ctrl_q) == ALU_OP_MULT) begin
            rsp_hi_d = alu_hi;
            rsp_lo_d = alu_lo;
          end
          alu_en_n_d    = 1'b1;
          alu_data_in_d = '0;
          alu_ctrl_d    = '0;
          alu_shamt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        req_ready_d   = 1'b0;
        alu_en_n_d    = 1'b1;
        alu_data_in_d = '0;
        alu_ctrl_d    = '0;
        alu_shamt_d   = '0;
        rsp_valid_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b0;
      alu_en_n_q    <= 1'b1;
      alu_data_in_q <= '0;
      alu_ctrl_q    <= '0;
      alu_shamt_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_status_q  <= '0;
      rsp_hi_q      <= '0;
      rsp_lo_q      <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      alu_en_n_q    <= alu_en_n_d;
      alu_data_in_q <= alu_data_in_d;
      alu_ctrl_q    <= alu_ctrl_d;
      alu_shamt_q   <= alu_shamt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      rsp_hi_q      <= rsp_hi_d;
      rsp_lo_q      <= rsp_lo_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign alu_en_n   = alu_en_n_q;
  assign alu_dataIn = alu_data_in_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_shamt  = alu_shamt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign rsp_hi     = rsp_hi_q;
  assign rsp_lo     = rsp_lo_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioural ALU and a response scoreboard.
module tb_alu_driver;

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 5;
  localparam int unsigned SW  = 4;
  localparam int unsigned SHW = 5;
  localparam int unsigned LAT = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  status;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [DW-1:0]   req_a, req_b;
  logic [CW-1:0]   req_op;
  logic [SHW-1:0]  req_shamt;
  logic            alu_en_n;
  logic [2*DW-1:0] alu_dataIn;
  logic [CW-1:0]   alu_ctrl;
  logic [SHW-1:0]  alu_shamt;
  logic [DW-1:0]   alu_dataOut;
  logic [SW-1:0]   alu_status;
  logic [DW-1:0]   alu_hi, alu_lo;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [SW-1:0]   rsp_status;
  logic [DW-1:0]   rsp_hi, rsp_lo;
  logic            rsp_err;
  logic            busy;

  rsp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   en_low_cnt = 0;

  always #5 clk = ~clk;

  alu_driver #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .STATUS_WIDTH(SW),
    .SHAMT_WIDTH(SHW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_shamt(req_shamt),
    .alu_en_n(alu_en_n), .alu_dataIn(alu_dataIn), .alu_ctrl(alu_ctrl),
    .alu_shamt(alu_shamt), .alu_dataOut(alu_dataOut), .alu_status(alu_status),
    .alu_hi(alu_hi), .alu_lo(alu_lo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU; garbage on its outputs whenever it is not enabled.
  always_comb begin
    logic [31:0] ma, mb;
    logic [63:0] prod;
    ma          = alu_dataIn[63:32];
    mb          = alu_dataIn[31:0];
    prod        = 64'(ma) * 64'(mb);
    alu_dataOut = 32'hDEADBEEF;
    alu_hi      = 32'hBAD0BAD0;
    alu_lo      = 32'hBAD0BAD0;
    alu_status  = 4'hF;
    if (!alu_en_n) begin
      case (alu_ctrl)
        5'h0:    alu_dataOut = ma & mb;
        5'h1:    alu_dataOut = ma | mb;
        5'h4:    alu_dataOut = ma + mb;
        5'h5:    alu_dataOut = ma - mb;
        5'h6:    alu_dataOut = prod[31:0];
        5'h8:    alu_dataOut = ma >> alu_shamt;
        default: alu_dataOut = 32'h0;
      endcase
      alu_hi     = prod[63:32];
      alu_lo     = prod[31:0];
      alu_status = {2'b00, alu_dataOut[31], (alu_dataOut == 32'h0)};
    end
  end

  // Count cycles in which the ALU was enabled.
  always @(posedge clk) begin
    if (alu_en_n === 1'b0) en_low_cnt <= en_low_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare every response handshake against the queue head.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got response data 0x%0h with nothing pending at %0t",
                   rsp_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data",   64'(rsp_data),   64'(e.data));
          check("rsp_status", 64'(rsp_status), 64'(e.status));
          check("rsp_hi",     64'(rsp_hi),     64'(e.hi));
          check("rsp_lo",     64'(rsp_lo),     64'(e.lo));
          check("rsp_err",    64'(rsp_err),    64'(e.err));
        end
      end
    end
  end

  // One full request/response transaction with cycle-accurate interface checks.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                        input logic [4:0] sh, input logic [4:0] exp_sh,
                        input rsp_t e, input bit stall);
    int   en_base;
    bit   legal;
    rsp_t snap;
    legal = (op <= 5'h0E);
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_shamt = sh;
    exp_q.push_back(e);
    en_base   = en_low_cnt;
    if (stall) rsp_ready = 1'b0;
    @(negedge clk);
    if (stall) begin
      req_a  = ~a;
      req_b  = ~b;
      req_op = 5'h1F;
    end else begin
      req_valid = 1'b0;
    end
    if (legal) begin
      for (int i = 0; i < int'(LAT); i++) begin
        check("issue_en_n",   64'(alu_en_n),   64'(0));
        check("issue_dataIn", 64'(alu_dataIn), {a, b});
        check("issue_ctrl",   64'(alu_ctrl),   64'(op));
        check("issue_shamt",  64'(alu_shamt),  64'(exp_sh));
        check("issue_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
      end
    end
    check("resp_valid",  64'(rsp_valid),  64'(1));
    check("resp_en_n",   64'(alu_en_n),   64'(1));
    check("resp_dataIn", 64'(alu_dataIn), 64'(0));
    check("resp_ctrl",   64'(alu_ctrl),   64'(0));
    check("resp_busy",   64'(busy),       64'(1));
    if (stall) begin
      snap = '{data: rsp_data, status: rsp_status, hi: rsp_hi, lo: rsp_lo, err: rsp_err};
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("stall_fields", 64'({rsp_data, rsp_status, rsp_err}),
              64'({snap.data, snap.status, snap.err}));
        check("stall_hilo",      {rsp_hi, rsp_lo}, {snap.hi, snap.lo});
        check("stall_valid",     64'(rsp_valid), 64'(1));
        check("stall_req_ready", 64'(req_ready), 64'(0));
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
    end
    @(negedge clk);
    check("post_rsp_valid", 64'(rsp_valid), 64'(0));
    check("post_req_ready", 64'(req_ready), 64'(1));
    check("post_busy",      64'(busy),      64'(0));
    check("en_low_cycles",  64'(en_low_cnt - en_base), legal ? 64'(LAT) : 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b1;
    req_a     = 32'h1;
    req_b     = 32'h2;
    req_op    = 5'h4;
    req_shamt = 5'h0;
    rsp_ready = 1'b1;

    // Reset held for three cycles with a request pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_en_n",      64'(alu_en_n),  64'(1));
    end
    check("rst_dataIn",    64'(alu_dataIn), 64'(0));
    check("rst_ctrl_sh",   64'({alu_ctrl, alu_shamt}), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data",  64'(rsp_data),  64'(0));
    check("rst_hilo",      {rsp_hi, rsp_lo}, 64'(0));
    check("rst_err_busy",  64'({rsp_err, busy, rsp_status}), 64'(0));
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("release_req_ready", 64'(req_ready), 64'(1));

    run_op(32'h0FFFFFFF, 32'h000FFFFF, 5'h0, 5'h0, 5'h0,
           '{data: 32'h000FFFFF, status: 4'h0, hi: 32'h0, lo: 32'h0, err: 1'b0}, 1'b0);
    run_op(32'h6, 32'h2, 5'h6, 5'h0, 5'h0,
           '{data: 32'hC, status: 4'h0, hi: 32'h0, lo: 32'hC, err: 1'b0}, 1'b0);
    run_op(32'hF0000001, 32'hF0000001, 5'h4, 5'h0, 5'h0,
           '{data: 32'hE0000002, status: 4'h2, hi: 32'h0, lo: 32'hC, err: 1'b0}, 1'b0);
    run_op(32'h0000000C, 32'h0, 5'h8, 5'h1, 5'h1,
           '{data: 32'h6, status: 4'h0, hi: 32'h0, lo: 32'hC, err: 1'b0}, 1'b0);
    run_op(32'h1, 32'h2, 5'h4, 5'h7, 5'h0,
           '{data: 32'h3, status: 4'h0, hi: 32'h0, lo: 32'hC, err: 1'b0}, 1'b0);
    run_op(32'h12345678, 32'h9ABCDEF0, 5'h1F, 5'h3, 5'h0,
           '{data: 32'h0, status: 4'h0, hi: 32'h0, lo: 32'hC, err: 1'b1}, 1'b0);
    run_op(32'h10, 32'h20, 5'h4, 5'h0, 5'h0,
           '{data: 32'h30, status: 4'h0, hi: 32'h0, lo: 32'hC, err: 1'b0}, 1'b1);

    // Reset in the middle of ISSUE discards the operation.
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = 32'h5;
    req_b     = 32'h7;
    req_op    = 5'h4;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_en_n_issue", 64'(alu_en_n), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("abort_en_n",      64'(alu_en_n),  64'(1));
    check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    check("abort_busy",      64'(busy),      64'(0));
    check("abort_hilo",      {rsp_hi, rsp_lo}, 64'(0));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(rsp_valid), 64'(0));
    end
    check("abort_req_ready", 64'(req_ready), 64'(1));

    run_op(32'h00010000, 32'h00010000, 5'h6, 5'h0, 5'h0,
           '{data: 32'h0, status: 4'h1, hi: 32'h1, lo: 32'h0, err: 1'b0}, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
